// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared width codes, FSM states and owner encoding for the memory bus arbiter
package mem_bus_pkg;
   localparam logic [1:0] W_BYTE = 2'd0;
   localparam logic [1:0] W_HALF = 2'd1;
   localparam logic [1:0] W_WORD = 2'd2;
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
   typedef enum logic {OWNER_C = 1'b0, OWNER_D = 1'b1} owner_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: D-over-C winner select with DMA run counter for CPU anti-starvation
//   clk, rst_n       clock, async active-low reset
//   d_req, c_req     pending requests
//   d_lock           DMA burst hint, sampled when D is acked
//   grant            arbiter is committing a winner this cycle
//   d_done           D transfer acknowledged this cycle
//   winner           combinational owner choice
module mem_arb_pick
   import mem_bus_pkg::*;
#(
   parameter int DMA_MAX_RUN = 16
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   d_req,
   input  logic   c_req,
   input  logic   d_lock,
   input  logic   grant,
   input  logic   d_done,
   output owner_t winner
);
   localparam int RW = $clog2(DMA_MAX_RUN + 1);
   logic [RW-1:0] run_q, run_d;
   logic          lock_q, lock_d, sat;
   // A locked burst keeps D ahead, but a saturated run counter always lets a waiting C in.
   always_comb begin
      sat    = run_q == RW'(DMA_MAX_RUN);
      winner = (d_req & (~(c_req & sat) | (lock_q & ~sat))) ? OWNER_D : OWNER_C;
      run_d  = !grant ? run_q : (winner == OWNER_C) ? '0 : (c_req & ~sat) ? run_q + RW'(1) : run_q;
      lock_d = d_done ? d_lock : (grant & winner == OWNER_C) ? 1'b0 : lock_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q  <= '0;
         lock_q <= 1'b0;
      end else begin
         run_q  <= run_d;
         lock_q <= lock_d;
      end
   end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between DMA (D) and CPU (C), one transfer at a time
//   clk, rst_n                              clock, async active-low reset
//   d_req/addr/wdata/width/we/lock, d_ack   DMA request side, one-cycle ack
//   c_req/addr/wdata/width/we, c_ack        CPU request side, one-cycle ack
//   rdata                                   read data, valid with an ack
//   mem_addr/wdata/width/read/write         registered memory request
//   mem_rdata, mem_ok                       memory data in, memory ready (0 = stall)
//   busy                                    arbiter not idle
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int MEM_LAT     = 1,
   parameter int DMA_MAX_RUN = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_width,
   input  logic        d_we,
   input  logic        d_lock,
   output logic        d_ack,
   input  logic        c_req,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   input  logic [1:0]  c_width,
   input  logic        c_we,
   output logic        c_ack,
   output logic [31:0] rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_width,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ok,
   output logic        busy
);
   localparam int LW = $clog2(MEM_LAT + 1);
   state_t        state_q, state_d;
   owner_t        owner_q, owner_d, winner;
   logic [LW-1:0] lat_q, lat_d;
   logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [1:0]    width_q, width_d;
   logic          rd_q, rd_d, wr_q, wr_d, grant, we_sel;
   mem_arb_pick #(.DMA_MAX_RUN(DMA_MAX_RUN)) u_pick (
      .clk(clk), .rst_n(rst_n), .d_req(d_req), .c_req(c_req), .d_lock(d_lock),
      .grant(grant), .d_done(d_ack), .winner(winner)
   );
   assign grant     = (state_q == IDLE) & (d_req | c_req);
   assign we_sel    = (winner == OWNER_D) ? d_we : c_we;
   assign d_ack     = (state_q == DONE) & (owner_q == OWNER_D);
   assign c_ack     = (state_q == DONE) & (owner_q == OWNER_C);
   assign busy      = state_q != IDLE;
   assign rdata     = rdata_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_width = width_q;
   assign mem_read  = rd_q;
   assign mem_write = wr_q;
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      lat_d   = lat_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      width_d = width_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: if (grant) begin
            owner_d = winner;
            addr_d  = (winner == OWNER_D) ? d_addr : c_addr;
            wdata_d = (winner == OWNER_D) ? d_wdata : c_wdata;
            width_d = (winner == OWNER_D) ? d_width : c_width;
            rd_d    = ~we_sel;
            wr_d    = we_sel;
            state_d = ACCESS;
         end
         // The latency count only advances on ready cycles; data is taken one ready
         // cycle after the count reaches MEM_LAT so synchronous RAM q is valid.
         ACCESS: if (mem_ok) begin
            if (lat_q == LW'(MEM_LAT)) begin
               rdata_d = rd_q ? mem_rdata : rdata_q;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = DONE;
            end else begin
               lat_d = lat_q + LW'(1);
            end
         end
         DONE: begin
            lat_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= OWNER_C;
         lat_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         width_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         lat_q   <= lat_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         width_q <= width_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and random checks of mem_bus_arbiter against a transfer-level model
module tb_mem_bus_arbiter;
   localparam int LAT  = 1;
   localparam int MAXR = 16;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        d_req = 0, d_we = 0, d_lock = 0, c_req = 0, c_we = 0, mem_ok = 1;
   logic [31:0] d_addr = 0, d_wdata = 0, c_addr = 0, c_wdata = 0, mem_rdata = 0;
   logic [1:0]  d_width = 0, c_width = 0;
   logic        d_ack, c_ack, mem_read, mem_write, busy;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [1:0]  mem_width;
   int checks = 0, errors = 0;
   // transfer-level model: is a transfer running, how many ready cycles it still needs, ack cycle
   bit          m_xfer, m_ack, m_own_d, m_rd;
   int          m_oks, m_run;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [1:0]  m_width;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.MEM_LAT(LAT), .DMA_MAX_RUN(MAXR)) dut (
      .clk(clk), .rst_n(rst_n),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_width(d_width), .d_we(d_we),
      .d_lock(d_lock), .d_ack(d_ack),
      .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_width(c_width), .c_we(c_we),
      .c_ack(c_ack), .rdata(rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ok(mem_ok),
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_xfer = 0; m_ack = 0; m_own_d = 0; m_rd = 0; m_oks = 0; m_run = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0; m_width = 0;
   endtask

   // One clock edge of the reference: a transfer needs MEM_LAT+1 ready cycles, then one ack cycle,
   // then one idle cycle before the next grant.
   task automatic model_edge();
      if (m_ack) m_ack = 0;
      else if (m_xfer) begin
         if (mem_ok) begin
            m_oks--;
            if (m_oks == 0) begin
               m_xfer = 0;
               m_ack  = 1;
               if (m_rd) m_rdata = mem_rdata;
            end
         end
      end else if (d_req || c_req) begin
         m_own_d = d_req && !(c_req && m_run == MAXR);
         if (!m_own_d) m_run = 0;
         else if (c_req && m_run < MAXR) m_run++;
         m_addr  = m_own_d ? d_addr : c_addr;
         m_wdata = m_own_d ? d_wdata : c_wdata;
         m_width = m_own_d ? d_width : c_width;
         m_rd    = m_own_d ? !d_we : !c_we;
         m_oks   = LAT + 1;
         m_xfer  = 1;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ctrl"}, 64'({d_ack, c_ack, busy, mem_read, mem_write}),
          64'({m_ack & m_own_d, m_ack & !m_own_d, m_xfer | m_ack, m_xfer & m_rd, m_xfer & !m_rd}));
      chk({tag, ".bus"}, {mem_addr, mem_wdata[29:0], mem_width}, {m_addr, m_wdata[29:0], m_width});
      chk({tag, ".rdata"}, 64'(rdata), 64'(m_rdata));
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      int d_at, c_at, rd_cyc, dn, acks, stall_hold;
      logic [31:0] got_rd;
      bit seq [$];
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk) rst_n = 1;

      // single C read
      c_req = 1; c_addr = 32'h0300_0010; c_we = 0; c_width = 2; mem_rdata = 32'hCAFE_F00D;
      c_at = -1; rd_cyc = 0; got_rd = 0;
      for (int i = 1; i <= 8; i++) begin
         tick("cread");
         if (mem_read) rd_cyc++;
         if (c_ack && c_at < 0) begin c_at = i; got_rd = rdata; c_req = 0; end
      end
      chk("cread.ack_cycle", 64'(c_at), 64'd3);
      chk("cread.read_cycles", 64'(rd_cyc), 64'd2);
      chk("cread.rdata", 64'(got_rd), 64'hCAFE_F00D);

      // simultaneous requests: D first, C served in the following slot
      d_req = 1; d_addr = 32'h0200_0000; d_we = 0; d_width = 2;
      c_req = 1; c_addr = 32'h0300_0020; mem_rdata = 32'h1111_2222;
      d_at = -1; c_at = -1;
      for (int i = 1; i <= 12; i++) begin
         tick("both");
         if (d_ack && d_at < 0) begin d_at = i; d_req = 0; mem_rdata = 32'h3333_4444; end
         if (c_ack && c_at < 0) begin c_at = i; c_req = 0; end
      end
      chk("both.d_first", 64'(d_at), 64'd3);
      chk("both.c_next", 64'(c_at), 64'd7);

      // DMA burst with waiting CPU: anti-starvation after MAXR D grants
      d_req = 1; d_lock = 1; c_req = 1;
      acks = 0;
      for (int i = 0; i < 120 && acks < 18; i++) begin
         tick("starve");
         if (d_ack) begin seq.push_back(1'b1); acks++; end
         if (c_ack) begin seq.push_back(1'b0); acks++; c_req = 0; end
      end
      chk("starve.acks_seen", 64'(acks), 64'd18);
      dn = 0;
      while (seq.size() > 0 && seq[0]) begin dn++; void'(seq.pop_front()); end
      chk("starve.d_run", 64'(dn), 64'(MAXR));
      chk("starve.c_then_d", 64'(seq.size() >= 2 ? {seq[0], seq[1]} : 2'b11), 64'b01);
      d_req = 0; d_lock = 0;
      repeat (4) tick("drain");

      // memory stall during ACCESS
      c_req = 1; c_addr = 32'h0300_0040; mem_rdata = 32'h5A5A_A5A5;
      tick("stall");
      mem_ok = 0; stall_hold = 0;
      for (int i = 0; i < 5; i++) begin
         tick("stall");
         if (mem_read && !c_ack) stall_hold++;
      end
      mem_ok = 1; c_at = -1;
      for (int i = 7; i <= 12; i++) begin
         tick("stall");
         if (c_ack && c_at < 0) begin c_at = i; c_req = 0; end
      end
      chk("stall.held", 64'(stall_hold), 64'd5);
      chk("stall.ack_cycle", 64'(c_at), 64'd8);

      // D halfword write
      d_req = 1; d_addr = 32'h0600_0000; d_width = 1; d_wdata = 32'h0000_1234; d_we = 1;
      tick("dwrite");
      chk("dwrite.strobes", 64'({mem_write, mem_read, mem_width}), 64'b1001);
      chk("dwrite.addr", 64'(mem_addr), 64'h0600_0000);
      dn = 0;
      for (int i = 0; i < 7; i++) begin
         tick("dwrite");
         if (d_ack) begin dn++; d_req = 0; end
      end
      chk("dwrite.ack_count", 64'(dn), 64'd1);
      d_we = 0;

      // async reset in the middle of ACCESS
      c_req = 1; c_addr = 32'h0300_0080; mem_rdata = 32'h0BAD_BEEF;
      tick("rst");
      tick("rst");
      #2 rst_n = 0;
      #1;
      model_reset();
      c_req = 0;
      chk("rst.outputs", 64'({d_ack, c_ack, busy, mem_read, mem_write, mem_width}), 64'd0);
      chk("rst.addr_rdata", {mem_addr, rdata}, 64'd0);
      @(negedge clk) rst_n = 1;
      c_req = 1; c_at = -1;
      for (int i = 1; i <= 6; i++) begin
         tick("after_rst");
         if (c_ack && c_at < 0) begin c_at = i; c_req = 0; end
      end
      chk("after_rst.ack_cycle", 64'(c_at), 64'd3);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         if ((d_req && m_ack && m_own_d) || (!d_req && $urandom_range(0, 2) == 0)) begin
            d_req = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
            d_width = 2'($urandom_range(0, 2)); d_we = $urandom_range(0, 1);
         end else if (d_req && $urandom_range(0, 40) == 0) d_req = 0;
         if ((c_req && m_ack && !m_own_d) || (!c_req && $urandom_range(0, 2) == 0)) begin
            c_req = $urandom_range(0, 1); c_addr = $urandom; c_wdata = $urandom;
            c_width = 2'($urandom_range(0, 2)); c_we = $urandom_range(0, 1);
         end else if (c_req && $urandom_range(0, 40) == 0) c_req = 0;
         d_lock = $urandom_range(0, 1);
         mem_ok = $urandom_range(0, 3) != 0;
         mem_rdata = $urandom;
         tick("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
